// File: rtl/pe_ctrl_pkg.sv
// Shared PE-controller definitions: sequencer state encoding and default datapath widths.
package pe_ctrl_pkg;

   localparam int PE_DW    = 16;
   localparam int PE_ACC_W = 32;

   // Explicit encodings keep state values stable for existing array-level controllers.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      MAC    = 3'd2,
      DRAIN  = 3'd3,
      RESULT = 3'd4
   } pe_state_e;

endpackage

// File: rtl/pe_dot_seq_if.sv
// Command, operand, PE-control and result signals of the dot-product sequencer.
interface pe_dot_seq_if #(
   parameter int DW    = 16,
   parameter int ACC_W = 32,
   parameter int LEN_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [LEN_W-1:0] cmd_len;
   logic [ACC_W-1:0] cmd_bias;

   logic             op_valid;
   logic             op_ready;
   logic [DW-1:0]    op_a;
   logic [DW-1:0]    op_b;

   logic             pe_en;
   logic             pe_load_acc;
   logic [DW-1:0]    pe_a;
   logic [DW-1:0]    pe_b;
   logic [ACC_W-1:0] pe_psum;
   logic [ACC_W-1:0] pe_acc;

   logic             res_valid;
   logic             res_ready;
   logic [ACC_W-1:0] res_data;
   logic             busy;

   // Environment side: issues commands/operands, hosts the PE, consumes results.
   modport master (
      output cmd_valid, cmd_len, cmd_bias, op_valid, op_a, op_b, pe_acc, res_ready,
      input  cmd_ready, op_ready, pe_en, pe_load_acc, pe_a, pe_b, pe_psum,
             res_valid, res_data, busy
   );

   // Sequencer side.
   modport slave (
      input  cmd_valid, cmd_len, cmd_bias, op_valid, op_a, op_b, pe_acc, res_ready,
      output cmd_ready, op_ready, pe_en, pe_load_acc, pe_a, pe_b, pe_psum,
             res_valid, res_data, busy
   );

endinterface

// File: rtl/pe_dot_seq.sv
// Dot-product sequencer for one MAC PE: bias preload, one en per operand pair, drain, result.
// Optional PE_DOT_SEQ_STALL_CNT_EN adds a saturating operand-stall counter output.
module pe_dot_seq
   import pe_ctrl_pkg::*;
#(
   parameter int DW     = PE_DW,
   parameter int ACC_W  = PE_ACC_W,
   parameter int LEN_W  = 8,
   parameter int PE_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   pe_dot_seq_if.slave bus
`ifdef PE_DOT_SEQ_STALL_CNT_EN
   ,
   output logic [15:0] stall_cnt
`endif
);

   localparam int DRN_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

   pe_state_e        state;
   logic [LEN_W-1:0] len_q;
   logic [ACC_W-1:0] bias_q;
   logic [LEN_W:0]   cnt;
   logic [LEN_W:0]   cnt_inc;
   logic [DRN_W-1:0] drain_cnt;
   logic             drain_last;
   logic [ACC_W-1:0] res_q;
   logic             cmd_fire;
   logic             mac_fire;

   // cmd_ready is masked by rst so the reset cycle never accepts a command.
   assign bus.cmd_ready   = (state == IDLE) && !rst;
   assign bus.op_ready    = (state == MAC);
   assign bus.pe_en       = (state == MAC) && bus.op_valid;
   assign bus.pe_load_acc = (state == LOAD);
   assign bus.pe_a        = bus.pe_en ? bus.op_a : DW'(0);
   assign bus.pe_b        = bus.pe_en ? bus.op_b : DW'(0);
   assign bus.pe_psum     = (state == LOAD) ? bias_q : '0;
   assign bus.res_valid   = (state == RESULT);
   assign bus.res_data    = res_q;
   assign bus.busy        = (state != IDLE);

   assign cmd_fire   = bus.cmd_valid && bus.cmd_ready;
   assign mac_fire   = bus.pe_en;
   assign cnt_inc    = cnt + (LEN_W + 1)'(1);
   assign drain_last = (drain_cnt == DRN_W'(PE_LAT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         len_q     <= '0;
         bias_q    <= '0;
         cnt       <= '0;
         drain_cnt <= '0;
         res_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_fire) begin
                  len_q  <= bus.cmd_len;
                  bias_q <= bus.cmd_bias;
                  cnt    <= '0;
                  state  <= LOAD;
               end
            end
            LOAD: begin
               drain_cnt <= '0;
               state     <= (len_q != '0) ? MAC : DRAIN;
            end
            MAC: begin
               if (mac_fire) begin
                  cnt <= cnt_inc;
                  if (cnt_inc == {1'b0, len_q}) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (drain_last) begin
                  res_q <= bus.pe_acc;
                  state <= RESULT;
               end else begin
                  drain_cnt <= drain_cnt + DRN_W'(1);
               end
            end
            RESULT: begin
               if (bus.res_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PE_DOT_SEQ_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst || cmd_fire) begin
         stall_cnt <= '0;
      end else if ((state == MAC) && !bus.op_valid && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule
